// File: rtl/pc_unit.sv
// Program counter unit with a BOOT/RUN/HALT control FSM.
// Selects the next PC from the sequential, branch or jump address. It also
// counts committed PC updates and flags misaligned targets.
//
// Ports:
//   clk, rst_n    - clock; synchronous active-low reset
//   PCadd4        - PC_o+4 from the external adder
//   BranchTarget  - branch destination
//   JumpTarget    - jump destination
//   PCSrc         - 00 seq, 01 branch, 10 jump, 11 seq
//   Stall         - hold PC this cycle
//   Halt, Resume  - enter / leave the HALT state
//   PC_o          - current PC (registered)
//   PC_valid      - PC_o is fetchable (RUN state)
//   Halted        - FSM is in HALT
//   InstCnt       - committed PC update count (wraps)
//   AlignErr      - one-cycle pulse on a misaligned target
//
// Configuration macro: PC_ALIGN_CHECK_EN
//   defined   - a misaligned update is rejected, pulses AlignErr and halts
//   undefined - the target is loaded with bits[1:0] cleared; AlignErr stays 0
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCadd4,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JumpTarget,
    input  logic [1:0]  PCSrc,
    input  logic        Stall,
    input  logic        Halt,
    input  logic        Resume,
    output logic [31:0] PC_o,
    output logic        PC_valid,
    output logic        Halted,
    output logic [31:0] InstCnt,
    output logic        AlignErr
);

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_d;
    logic [XLEN-1:0] sel_addr;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] cnt_d;
    logic            err_d;

    // Next-address mux; the reserved encoding falls back to sequential.
    always_comb begin
        sel_addr = PCadd4;
        case (PCSrc)
            2'b01:   sel_addr = BranchTarget;
            2'b10:   sel_addr = JumpTarget;
            default: sel_addr = PCadd4;
        endcase
    end

    // Next-state and next-output decode. Priority in RUN is Halt > Stall > update.
    always_comb begin
        state_d = state;
        pc_d    = PC_o;
        cnt_d   = InstCnt;
        err_d   = 1'b0;
        case (state)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (Halt) begin
                    state_d = ST_HALT;
                end else if (!Stall) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (sel_addr[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d  = sel_addr;
                        cnt_d = InstCnt + XLEN'(1);
                    end
`else
                    pc_d  = sel_addr & ~XLEN'(3);
                    cnt_d = InstCnt + XLEN'(1);
`endif
                end
            end
            ST_HALT: begin
                // A simultaneous Halt keeps the unit parked.
                if (Resume && !Halt) state_d = ST_RUN;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // State and output registers; status flags follow the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            PC_o     <= RESET_PC;
            InstCnt  <= '0;
            AlignErr <= 1'b0;
            PC_valid <= 1'b0;
            Halted   <= 1'b0;
        end else begin
            state    <= state_d;
            PC_o     <= pc_d;
            InstCnt  <= cnt_d;
            AlignErr <= err_d;
            PC_valid <= (state_d == ST_RUN);
            Halted   <= (state_d == ST_HALT);
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit. The driver applies one input vector per cycle.
// It also advances a behavioural model and queues the expected outputs.
// A monitor pops the queue and compares after each rising edge.
module tb_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        halted;
        logic [31:0] cnt;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_add4;
    logic [31:0] br_tgt;
    logic [31:0] jmp_tgt;
    logic [1:0]  pc_src;
    logic        stall;
    logic        halt;
    logic        resume;
    logic [31:0] pc_o;
    logic        pc_valid;
    logic        halted;
    logic [31:0] inst_cnt;
    logic        align_err;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_fail;

    // Reference model state
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_err;

    pc_unit #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PCadd4       (pc_add4),
        .BranchTarget (br_tgt),
        .JumpTarget   (jmp_tgt),
        .PCSrc        (pc_src),
        .Stall        (stall),
        .Halt         (halt),
        .Resume       (resume),
        .PC_o         (pc_o),
        .PC_valid     (pc_valid),
        .Halted       (halted),
        .InstCnt      (inst_cnt),
        .AlignErr     (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue what the next rising edge must produce.
    task automatic step(input logic rst, input logic [1:0] src, input logic [31:0] br,
                        input logic [31:0] jt, input logic stl, input logic hlt, input logic res);
        logic [31:0] tgt;
        exp_t e;
        @(negedge clk);
        rst_n   = rst;
        pc_src  = src;
        br_tgt  = br;
        jmp_tgt = jt;
        pc_add4 = m_pc + 32'd4;
        stall   = stl;
        halt    = hlt;
        resume  = res;

        m_err = 1'b0;
        if (!rst) begin
            m_mode = M_BOOT;
            m_pc   = RST_PC;
            m_cnt  = 32'd0;
        end else if (m_mode == M_BOOT) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (hlt) begin
                m_mode = M_HALT;
            end else if (!stl) begin
                tgt = (src == 2'b01) ? br : (src == 2'b10) ? jt : pc_add4;
`ifdef PC_ALIGN_CHECK_EN
                if (tgt % 4 != 0) begin
                    m_err  = 1'b1;
                    m_mode = M_HALT;
                end else begin
                    m_pc  = tgt;
                    m_cnt = m_cnt + 32'd1;
                end
`else
                m_pc  = tgt - (tgt % 4);
                m_cnt = m_cnt + 32'd1;
`endif
            end
        end else begin
            if (res && !hlt) m_mode = M_RUN;
        end

        e.pc     = m_pc;
        e.valid  = (m_mode == M_RUN);
        e.halted = (m_mode == M_HALT);
        e.cnt    = m_cnt;
        e.err    = m_err;
        exp_q.push_back(e);
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every rising edge with a pending expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pc",       pc_o,             e.pc);
                check("pc_valid", 32'(pc_valid),    32'(e.valid));
                check("halted",   32'(halted),      32'(e.halted));
                check("inst_cnt", inst_cnt,         e.cnt);
                check("align_err", 32'(align_err),  32'(e.err));
            end
        end
    end

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        m_mode  = M_BOOT;
        m_pc    = RST_PC;
        m_cnt   = 32'd0;
        m_err   = 1'b0;
        rst_n   = 1'b0;
        pc_add4 = 32'd4;
        br_tgt  = 32'd0;
        jmp_tgt = 32'd0;
        pc_src  = 2'b00;
        stall   = 1'b0;
        halt    = 1'b0;
        resume  = 1'b0;

        // Reset, BOOT, then two sequential updates.
        step(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        seq(3);
        // Branch, jump, and the reserved select.
        step(1'b1, 2'b10, 32'h0, 32'h100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'b01, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'b10, 32'h0, 32'h40, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'b11, 32'h999, 32'h777, 1'b0, 1'b0, 1'b0);
        // Stall at 0x20, then Halt together with Stall.
        step(1'b1, 2'b10, 32'h0, 32'h1C, 1'b0, 1'b0, 1'b0);
        seq(1);
        step(1'b1, 2'b10, 32'h0, 32'h80, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'b10, 32'h0, 32'h80, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'b10, 32'h0, 32'h80, 1'b1, 1'b1, 1'b0);
        // Halt+Resume stays halted; Resume alone returns to RUN with PC held.
        step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        seq(1);
        // Resume in RUN is ignored.
        step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        // Reset while halted.
        step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 2'b01, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        seq(2);
        // Misaligned branch target.
        step(1'b1, 2'b01, 32'h202, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        seq(1);
        // PC wraps modulo 2^32 from the top word.
        step(1'b1, 2'b10, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        seq(2);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] b;
            logic [31:0] j;
            b = $urandom();
            j = $urandom();
            if ($urandom_range(0, 3) != 0) b = b & ~32'h3;
            if ($urandom_range(0, 3) != 0) j = j & ~32'h3;
            step(($urandom_range(0, 79) != 0), 2'($urandom_range(0, 3)), b, j,
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 14) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
